count_month: RTL and testbench
==============================

Name: count_month

Overview:
- BCD month counter for the calendar chain; sequence 01→02→…→12→01.
- Advances one step per clock while the enable from the day stage is high.
- Drives the month display digits (tens/units) and a carry pulse to the year stage on the 12→01 wrap.

Parameters:
- MONTH_RESET, 1, month loaded on reset; legal 1..12. Split into ten = MONTH_RESET/10 and unit = MONTH_RESET%10.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en_mo  input  1  count enable; the month advances on every rising clk edge where en_mo=1.
- month_unit  output  4  BCD units digit of the month; 0..9.
- month_ten  output  2  BCD tens digit of the month; 0..1.
- pulse_mo  output  1  month-wrap carry to the year counter.

Behaviour:
- State is the two BCD registers month_ten and month_unit, driven directly to the outputs.
- Reset: rst_n=0 asynchronously forces the state to MONTH_RESET (default ten=0, unit=1, i.e. 01), independent of clk.
  - pulse_mo follows from that state: 0 for the default.
  - Release of rst_n has no effect until the next rising edge with en_mo=1.
- Rising edge, en_mo=0: hold the state.
- Rising edge, en_mo=1, next month:
  - From 12 (ten=1, unit=2): go to 01 (ten=0, unit=1).
  - From 09 (ten=0, unit=9): go to 10 (ten=1, unit=0).
  - Otherwise: unit+1, ten unchanged.
- Latency: outputs change one clock after the enabling edge. There is no pipelining beyond the state registers.
- pulse_mo is combinational: pulse_mo = en_mo AND (ten==1) AND (unit==2).
  - High for exactly the cycle in which the enabled edge will wrap 12→01.
  - One pulse per 12 enabled edges.
  - Low whenever en_mo=0.
- Continuous en_mo=1 gives a period-12 sequence: 01,02,…,09,10,11,12,01,…
- Illegal states (unit>9, ten>1, 00, 13..19): any enabled edge loads 01. pulse_mo=0 in these states. Held when en_mo=0.
- Reset mid-count: immediate return to MONTH_RESET. The count restarts from there.

Optional Feature:
- Macro: COUNT_MONTH_PULSE_REG_EN.
- Defined: pulse_mo is a flop.
  - Set on the enabled edge that performs the 12→01 wrap; cleared on the next edge.
  - It is therefore high for the first cycle the display reads 01 after a wrap, independent of en_mo in that cycle.
  - Reset value 0.
- Undefined: pulse_mo is the combinational carry described in Behaviour.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks → month_ten=0, month_unit=1, pulse_mo=0; outputs stay 01 after release with en_mo=0.
- Continuous count: en_mo=1 for 60 edges from 01.
  - After edge k, month = (k mod 12)+1, so edge 1→02, edge 9→10, edge 11→12, edge 12→01.
  - pulse_mo=1 only while month=12 (5 occurrences), else 0.
- Hold: at month 07 drop en_mo for 5 clocks → stays 07, pulse_mo=0; re-enable → 08.
- Enable gating at 12: reach 12, then en_mo=0 → pulse_mo=0 and month stays 12; en_mo=1 → pulse_mo=1, next edge 01.
- Async reset mid-count: at month 10 pulse rst_n low between edges → outputs read 01 before the next clk edge.
- With COUNT_MONTH_PULSE_REG_EN: pulse_mo=1 only in the cycle after the 12→01 edge, 5 times in 60 edges.

Source files
------------

// File: rtl/count_month.sv
// BCD month counter (01..12) with a carry pulse to the year stage.
// Define COUNT_MONTH_PULSE_REG_EN to register pulse_mo after the wrap.
module count_month #(
    parameter int MONTH_RESET = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_mo,
    output logic [3:0] month_unit,
    output logic [1:0] month_ten,
    output logic       pulse_mo
);

    localparam logic [1:0] RST_TEN  = 2'(MONTH_RESET / 10);
    localparam logic [3:0] RST_UNIT = 4'(MONTH_RESET % 10);

    logic [1:0] r_ten;
    logic [3:0] r_unit;
    logic [1:0] w_ten_nxt;
    logic [3:0] w_unit_nxt;
    logic       w_legal;
    logic       w_at_12;

    assign w_at_12 = (r_ten == 2'd1) && (r_unit == 4'd2);

    assign w_legal =
        ((r_ten == 2'd0) && (r_unit >= 4'd1) && (r_unit <= 4'd9)) ||
        ((r_ten == 2'd1) && (r_unit <= 4'd2));

    // Illegal states and the 12 wrap both land on 01.
    always_comb begin
        w_ten_nxt  = 2'd0;
        w_unit_nxt = 4'd1;
        if (w_legal && !w_at_12) begin
            if (r_unit == 4'd9) begin
                w_ten_nxt  = 2'd1;
                w_unit_nxt = 4'd0;
            end else begin
                w_ten_nxt  = r_ten;
                w_unit_nxt = r_unit + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ten  <= RST_TEN;
            r_unit <= RST_UNIT;
        end else if (en_mo) begin
            r_ten  <= w_ten_nxt;
            r_unit <= w_unit_nxt;
        end
    end

    assign month_ten  = r_ten;
    assign month_unit = r_unit;

`ifdef COUNT_MONTH_PULSE_REG_EN
    logic r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= en_mo && w_at_12;
        end
    end

    assign pulse_mo = r_pulse;
`else
    assign pulse_mo = en_mo && w_at_12;
`endif

endmodule

// File: tb/tb_count_month.sv
// Randomized self-checking bench for count_month.
// Reference keeps the month as an integer 1..12.
module tb_count_month;

    logic       clk;
    logic       rst_n;
    logic       en_mo;
    logic [3:0] month_unit;
    logic [1:0] month_ten;
    logic       pulse_mo;

    int n_err;
    int n_chk;
    int m_month;
    bit m_preg;
    int n_pulse;

    count_month #(.MONTH_RESET(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_mo     (en_mo),
        .month_unit(month_unit),
        .month_ten (month_ten),
        .pulse_mo  (pulse_mo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input int got,
                         input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d",
                     tag, got, exp);
        end
    endtask

    task automatic check_month(input string tag);
        check({tag, "_ten"}, int'(month_ten), m_month / 10);
        check({tag, "_unit"}, int'(month_unit), m_month % 10);
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic step(input bit en, input string tag);
        bit wrap;
        en_mo = en;
        #1;
`ifndef COUNT_MONTH_PULSE_REG_EN
        check({tag, "_pulse"}, int'(pulse_mo),
              int'(en && m_month == 12));
        if (pulse_mo) n_pulse++;
`endif
        @(posedge clk);
        wrap = en && (m_month == 12);
        if (en) m_month = (m_month % 12) + 1;
        m_preg = wrap;
        @(negedge clk);
        check_month(tag);
`ifdef COUNT_MONTH_PULSE_REG_EN
        check({tag, "_pulse"}, int'(pulse_mo), int'(m_preg));
        if (pulse_mo) n_pulse++;
`endif
    endtask

    task automatic run_to(input int target, input string tag);
        for (int i = 0; i < 12 && m_month != target; i++)
            step(1'b1, tag);
        check({tag, "_reach"}, m_month, target);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_err   = 0;
        n_chk   = 0;
        n_pulse = 0;
        m_month = 1;
        m_preg  = 1'b0;
        rst_n   = 1'b0;
        en_mo   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_month("rst");
        check("rst_pulse", int'(pulse_mo), 0);
        rst_n = 1'b1;
        repeat (3) step(1'b0, "rel");

        n_pulse = 0;
        for (int k = 1; k <= 60; k++)
            step(1'b1, "cont");
        check("cont_npulse", n_pulse, 5);
        check("cont_end", m_month, 1);

        run_to(7, "hold");
        repeat (5) step(1'b0, "hold");
        step(1'b1, "hold_re");
        check("hold_re_m", m_month, 8);

        run_to(12, "gate");
        step(1'b0, "gate_off");
        step(1'b0, "gate_off");
        step(1'b1, "gate_on");
        check("gate_wrap", m_month, 1);
        step(1'b0, "gate_after");

        run_to(10, "arst");
        #2;
        rst_n = 1'b0;
        m_month = 1;
        m_preg  = 1'b0;
        #1;
        check_month("arst_now");
        check("arst_pulse", int'(pulse_mo), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, "arst_hold");
        step(1'b1, "arst_cnt");

        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), "rnd");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
